// File: rtl/taiga_event_counter_bank.sv
// Bank of performance counters fed by per-cycle multi-bit event increments.
// Each channel keeps a live counter, a sticky overflow flag and a shadow copy.
// Shadows are loaded atomically by a manual or periodic snapshot and are read
// through a registered single-port read interface.

// One counter channel: live count, sticky overflow and its shadow copy.
module taiga_ecb_lane #(
    parameter int COUNTER_W = 32,
    parameter int INC_W     = 4,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INC_W-1:0]     inc,
    input  logic                 clear,
    input  logic                 snap,
    output logic [COUNTER_W-1:0] shadow,
    output logic                 shadow_ovf
);
    logic [COUNTER_W-1:0] live;
    logic [COUNTER_W-1:0] live_nxt;
    logic                 ovf;
    logic                 ovf_nxt;
    logic [COUNTER_W:0]   sum;
    logic                 carry;

    // One extra bit so the carry-out is the overflow indication.
    assign sum     = {1'b0, live} + (COUNTER_W+1)'(inc);
    assign carry   = sum[COUNTER_W];
    assign ovf_nxt = ovf | carry;

    generate
        if (SATURATE != 0) begin : g_sat
            // Clamp at all-ones; a saturated counter carries on any non-zero inc,
            // so it stays pinned.
            assign live_nxt = carry ? {COUNTER_W{1'b1}} : sum[COUNTER_W-1:0];
        end else begin : g_wrap
            assign live_nxt = sum[COUNTER_W-1:0];
        end
    endgenerate

    // Live update (clear wins over the pending increment) and shadow capture
    // of the post-update value, so snapshot+clear sees the pre-clear count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live       <= '0;
            ovf        <= 1'b0;
            shadow     <= '0;
            shadow_ovf <= 1'b0;
        end else begin
            if (clear) begin
                live <= '0;
                ovf  <= 1'b0;
            end else begin
                live <= live_nxt;
                ovf  <= ovf_nxt;
            end
            if (snap) begin
                shadow     <= live_nxt;
                shadow_ovf <= ovf_nxt;
            end
        end
    end
endmodule

module taiga_event_counter_bank #(
    parameter int NUM_EVENTS  = 32,
    parameter int COUNTER_W   = 32,
    parameter int INC_W       = 4,
    parameter int SATURATE    = 0,
    parameter int SNAP_PERIOD = 0,
    parameter int ADDR_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        count_en,
    input  logic [NUM_EVENTS*INC_W-1:0] event_inc,
    input  logic                        snapshot_req,
    input  logic                        clear_req,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_valid,
    output logic [COUNTER_W-1:0]        rd_data,
    output logic                        rd_overflow,
    output logic                        rd_err,
    output logic                        snap_done
);
    typedef struct packed {
        logic [COUNTER_W-1:0] data;
        logic                 ovf;
        logic                 err;
    } rd_rsp_t;

    logic [NUM_EVENTS-1:0][INC_W-1:0]     inc_r;
    logic [NUM_EVENTS-1:0][COUNTER_W-1:0] shadow;
    logic [NUM_EVENTS-1:0]                shadow_ovf;
    logic                                 tick;
    logic                                 snap_fire;
    logic [31:0]                          addr_ext;
    rd_rsp_t                              rsp_nxt;
    rd_rsp_t                              rsp_q;

    // Input stage: retime the wide event bus; disabled counting feeds zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) inc_r <= '0;
        else        inc_r <= count_en ? event_inc : '0;
    end

    generate
        if (SNAP_PERIOD > 0) begin : g_auto
            localparam int            PW     = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;
            localparam logic [PW-1:0] RELOAD = PW'(SNAP_PERIOD - 1);
            logic [PW-1:0] per_cnt;

            assign tick = (per_cnt == '0);

            // Down-counter for periodic snapshots; clear restarts the interval.
            always_ff @(posedge clk) begin
                if (!rst_n)                 per_cnt <= RELOAD;
                else if (clear_req || tick) per_cnt <= RELOAD;
                else                        per_cnt <= per_cnt - 1'b1;
            end
        end else begin : g_no_auto
            assign tick = 1'b0;
        end
    endgenerate

    // Manual and periodic requests merge into one snapshot and one pulse.
    assign snap_fire = snapshot_req | tick;

    generate
        for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_lane
            taiga_ecb_lane #(
                .COUNTER_W (COUNTER_W),
                .INC_W     (INC_W),
                .SATURATE  (SATURATE)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .inc        (inc_r[g]),
                .clear      (clear_req),
                .snap       (snap_fire),
                .shadow     (shadow[g]),
                .shadow_ovf (shadow_ovf[g])
            );
        end
    endgenerate

    // Snapshot completion pulse, one cycle after capture.
    always_ff @(posedge clk) begin
        if (!rst_n) snap_done <= 1'b0;
        else        snap_done <= snap_fire;
    end

    assign addr_ext = 32'(rd_addr);

    // Read mux over the shadow bank; out-of-range addresses return an error.
    always_comb begin
        rsp_nxt = '0;
        if (addr_ext >= 32'(NUM_EVENTS)) begin
            rsp_nxt.err = 1'b1;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (addr_ext == 32'(i)) begin
                    rsp_nxt.data = shadow[i];
                    rsp_nxt.ovf  = shadow_ovf[i];
                end
            end
        end
    end

    // Registered read response; payload holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rsp_q    <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rsp_q <= rsp_nxt;
        end
    end

    assign rd_data     = rsp_q.data;
    assign rd_overflow = rsp_q.ovf;
    assign rd_err      = rsp_q.err;
endmodule

// File: tb/tb_taiga_event_counter_bank.sv
// Bench for taiga_event_counter_bank: three instances (wrap, saturate,
// wrap with 16-cycle auto-snapshot) share one stimulus stream and are checked
// against an arithmetic reference model of the counter bank.
module tb_taiga_event_counter_bank;
    localparam int NE = 6;
    localparam int CW = 8;
    localparam int IW = 4;
    localparam int AW = 3;
    localparam int MAXV = 255;

    logic          clk;
    logic          rst_n;
    logic          count_en;
    logic [NE*IW-1:0] event_inc;
    logic          snapshot_req;
    logic          clear_req;
    logic          rd_req;
    logic [AW-1:0] rd_addr;

    logic [2:0]         rv, ro, re, sd;
    logic [2:0][CW-1:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    taiga_event_counter_bank #(.NUM_EVENTS(NE), .COUNTER_W(CW), .INC_W(IW),
        .SATURATE(0), .SNAP_PERIOD(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .event_inc(event_inc),
        .snapshot_req(snapshot_req), .clear_req(clear_req), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(rv[0]), .rd_data(rd[0]),
        .rd_overflow(ro[0]), .rd_err(re[0]), .snap_done(sd[0]));

    taiga_event_counter_bank #(.NUM_EVENTS(NE), .COUNTER_W(CW), .INC_W(IW),
        .SATURATE(1), .SNAP_PERIOD(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .event_inc(event_inc),
        .snapshot_req(snapshot_req), .clear_req(clear_req), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(rv[1]), .rd_data(rd[1]),
        .rd_overflow(ro[1]), .rd_err(re[1]), .snap_done(sd[1]));

    taiga_event_counter_bank #(.NUM_EVENTS(NE), .COUNTER_W(CW), .INC_W(IW),
        .SATURATE(0), .SNAP_PERIOD(16)) u_auto (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .event_inc(event_inc),
        .snapshot_req(snapshot_req), .clear_req(clear_req), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(rv[2]), .rd_data(rd[2]),
        .rd_overflow(ro[2]), .rd_err(re[2]), .snap_done(sd[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer counts, cycles-since-last-period counter.
    int m_live[3][NE];
    int m_ovf[3][NE];
    int m_sh[3][NE];
    int m_sho[3][NE];
    int m_pend[NE];
    int m_since;
    bit m_rv[3];
    int m_rd[3];
    bit m_ro[3];
    bit m_re[3];
    bit m_sd[3];

    always @(posedge clk) begin
        bit snap;
        int s;
        int post;
        int povf;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                for (int ch = 0; ch < NE; ch++) begin
                    m_live[c][ch] = 0; m_ovf[c][ch] = 0;
                    m_sh[c][ch] = 0;   m_sho[c][ch] = 0;
                end
                m_rv[c] = 0; m_rd[c] = 0; m_ro[c] = 0; m_re[c] = 0; m_sd[c] = 0;
            end
            m_since = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                snap = snapshot_req || (c == 2 && m_since == 15);
                m_rv[c] = rd_req;
                if (rd_req) begin
                    if (int'(rd_addr) >= NE) begin
                        m_rd[c] = 0; m_ro[c] = 0; m_re[c] = 1;
                    end else begin
                        m_rd[c] = m_sh[c][rd_addr];
                        m_ro[c] = m_sho[c][rd_addr] != 0;
                        m_re[c] = 0;
                    end
                end
                for (int ch = 0; ch < NE; ch++) begin
                    s = m_live[c][ch] + m_pend[ch];
                    if (s > MAXV) post = (c == 1) ? MAXV : s - (MAXV + 1);
                    else          post = s;
                    povf = (m_ovf[c][ch] != 0 || s > MAXV) ? 1 : 0;
                    if (snap) begin
                        m_sh[c][ch] = post;
                        m_sho[c][ch] = povf;
                    end
                    if (clear_req) begin
                        m_live[c][ch] = 0; m_ovf[c][ch] = 0;
                    end else begin
                        m_live[c][ch] = post; m_ovf[c][ch] = povf;
                    end
                end
                m_sd[c] = snap;
            end
            m_since = (clear_req || m_since == 15) ? 0 : m_since + 1;
        end
        for (int ch = 0; ch < NE; ch++)
            m_pend[ch] = (rst_n && count_en) ? int'(event_inc[ch*IW +: IW]) : 0;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        count_en = 1'b1; event_inc = '0; snapshot_req = 1'b0;
        clear_req = 1'b0; rd_req = 1'b0; rd_addr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; count_en = 1'b1; event_inc = '1;
        snapshot_req = 1'b1; clear_req = 1'b0; rd_req = 1'b1; rd_addr = '0;
        step(2);
        n_checks++;
        if (rv !== 3'b000) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 000", rv); end
        n_checks++;
        if (sd !== 3'b000) begin n_fail++; $display("FAIL reset_snap_done: got %b expected 000", sd); end
        idle();
        rst_n = 1'b1;
        for (int a = 0; a < NE; a++) begin
            rd_req = 1'b1; rd_addr = AW'(a);
            step(1);
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (rv[c] !== 1'b1 || rd[c] !== 8'd0 || ro[c] !== 1'b0 || re[c] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_read dut%0d ch%0d: got v=%b d=%0d o=%b e=%b expected v=1 d=0 o=0 e=0",
                             c, a, rv[c], rd[c], ro[c], re[c]);
                end
            end
            n_checks++;
            if (sd[1:0] !== 2'b00) begin n_fail++; $display("FAIL reset_snap_idle: got %b expected 00", sd[1:0]); end
        end
        idle();
        step(1);
    endtask

    task automatic test_latency();
        int exp;
        for (int k = 0; k < 3; k++) begin
            idle(); clear_req = 1'b1; step(1); clear_req = 1'b0; step(1);
            for (int j = 0; j < 4; j++) begin
                event_inc = '0;
                if (j == 0) event_inc[3*IW +: IW] = 4'd5;
                snapshot_req = (j == k);
                step(1);
            end
            idle();
            n_checks++;
            if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL latency_no_read: got %b expected 0", rv[0]); end
            rd_req = 1'b1; rd_addr = 3'd3;
            step(1);
            rd_req = 1'b0;
            exp = (k == 0) ? 0 : 5;
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (rv[c] !== 1'b1 || rd[c] !== 8'(exp)) begin
                    n_fail++;
                    $display("FAIL latency snap+%0d dut%0d: got v=%b d=%0d expected v=1 d=%0d", k, c, rv[c], rd[c], exp);
                end
            end
        end
    endtask

    task automatic test_wrap_saturate();
        idle(); clear_req = 1'b1; step(1); clear_req = 1'b0;
        event_inc[0 +: IW] = 4'd4;
        step(65);
        idle(); step(1);
        snapshot_req = 1'b1; step(1); snapshot_req = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd0; step(1);
        n_checks++;
        if (rd[0] !== 8'd4 || ro[0] !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got d=%0d o=%b expected d=4 o=1", rd[0], ro[0]);
        end
        n_checks++;
        if (rd[1] !== 8'd255 || ro[1] !== 1'b1) begin
            n_fail++; $display("FAIL saturate: got d=%0d o=%b expected d=255 o=1", rd[1], ro[1]);
        end
        rd_addr = 3'd1; step(1); rd_req = 1'b0;
        n_checks++;
        if (rd[0] !== 8'd0 || ro[0] !== 1'b0 || rd[1] !== 8'd0 || ro[1] !== 1'b0) begin
            n_fail++; $display("FAIL wrap_other_ch: got d=%0d/%0d o=%b/%b expected 0", rd[0], rd[1], ro[0], ro[1]);
        end
    endtask

    task automatic test_snap_clear();
        idle(); clear_req = 1'b1; step(1); clear_req = 1'b0;
        event_inc[1*IW +: IW] = 4'd10;
        step(10);
        event_inc[1*IW +: IW] = 4'd2;
        step(1);
        event_inc = '0; snapshot_req = 1'b1; clear_req = 1'b1;
        step(1);
        idle(); rd_req = 1'b1; rd_addr = 3'd1; step(1); rd_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (rd[c] !== 8'd102 || ro[c] !== 1'b0) begin
                n_fail++; $display("FAIL snap_clear dut%0d: got d=%0d o=%b expected d=102 o=0", c, rd[c], ro[c]);
            end
        end
        snapshot_req = 1'b1; step(1); snapshot_req = 1'b0;
        rd_req = 1'b1; step(1); rd_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (rd[c] !== 8'd0) begin
                n_fail++; $display("FAIL snap_after_clear dut%0d: got d=%0d expected 0", c, rd[c]);
            end
        end
    endtask

    task automatic test_auto_snapshot();
        bit found;
        idle(); rst_n = 1'b0; step(1); rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            n_checks++;
            if (sd[2] !== ((k % 16) == 0) || sd[0] !== 1'b0) begin
                n_fail++; $display("FAIL auto_period cycle %0d: got auto=%b manual=%b expected auto=%b manual=0",
                                   k, sd[2], sd[0], (k % 16) == 0);
            end
        end
        clear_req = 1'b1; step(1); clear_req = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step(1);
            n_checks++;
            if (sd[2] !== (j == 16)) begin
                n_fail++; $display("FAIL auto_after_clear cycle %0d: got %b expected %b", j, sd[2], j == 16);
            end
        end
        found = 0;
        for (int w = 0; w < 20 && !found; w++) begin
            if (m_since == 15) found = 1;
            else step(1);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL auto_tick_search: got timeout expected tick within 20 cycles"); end
        snapshot_req = 1'b1; step(1); snapshot_req = 1'b0;
        n_checks++;
        if (sd[2] !== 1'b1 || sd[0] !== 1'b1) begin
            n_fail++; $display("FAIL manual_on_tick: got auto=%b manual=%b expected 1/1", sd[2], sd[0]);
        end
        step(1);
        n_checks++;
        if (sd[2] !== 1'b0) begin n_fail++; $display("FAIL manual_on_tick_single: got %b expected 0", sd[2]); end
    endtask

    task automatic test_back_to_back_read();
        logic [AW-1:0] addrs [5];
        int            exp_d [5];
        addrs = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd2};
        exp_d = '{1, 2, 3, 0, 3};
        idle(); clear_req = 1'b1; step(1); clear_req = 1'b0;
        event_inc[0 +: IW] = 4'd1; event_inc[IW +: IW] = 4'd2; event_inc[2*IW +: IW] = 4'd3;
        step(1);
        idle(); step(1);
        snapshot_req = 1'b1; step(1); snapshot_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1; rd_addr = addrs[i];
            step(1);
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (rv[c] !== 1'b1 || rd[c] !== 8'(exp_d[i]) || ro[c] !== 1'b0 || re[c] !== (addrs[i] >= NE)) begin
                    n_fail++;
                    $display("FAIL b2b_read %0d dut%0d: got v=%b d=%0d o=%b e=%b expected v=1 d=%0d o=0 e=%b",
                             i, c, rv[c], rd[c], ro[c], re[c], exp_d[i], addrs[i] >= NE);
                end
            end
        end
        rd_req = 1'b0; step(2);
        n_checks++;
        if (rv[0] !== 1'b0 || rd[0] !== 8'd3 || re[0] !== 1'b0) begin
            n_fail++; $display("FAIL read_hold: got v=%b d=%0d e=%b expected v=0 d=3 e=0", rv[0], rd[0], re[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            count_en     = ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < NE; ch++) event_inc[ch*IW +: IW] = IW'($urandom);
            snapshot_req = ($urandom_range(0, 7) == 0);
            clear_req    = ($urandom_range(0, 39) == 0);
            rd_req       = $urandom_range(0, 1) == 1;
            rd_addr      = AW'($urandom);
            step(1);
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (rv[c] !== m_rv[c] || sd[c] !== m_sd[c] || rd[c] !== 8'(m_rd[c]) ||
                    ro[c] !== m_ro[c] || re[c] !== m_re[c]) begin
                    n_fail++;
                    $display("FAIL random cyc%0d dut%0d: got v=%b s=%b d=%0d o=%b e=%b expected v=%b s=%b d=%0d o=%b e=%b",
                             n, c, rv[c], sd[c], rd[c], ro[c], re[c],
                             m_rv[c], m_sd[c], m_rd[c], m_ro[c], m_re[c]);
                end
            end
        end
        rst_n = 1'b1; idle(); step(2);
    endtask

    initial begin
        rst_n = 1'b0; count_en = 1'b0; event_inc = '0; snapshot_req = 1'b0;
        clear_req = 1'b0; rd_req = 1'b0; rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_wrap_saturate();
        test_snap_clear();
        test_auto_snapshot();
        test_back_to_back_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
